// File: rtl/uart_tx_if.sv
// Byte-level handshake between the UART register block and the transmitter.
// The register block drives tx_data/tx_start; the transmitter reports
// tx_busy/tx_done.
//
// Handshake: tx_start is a request that is accepted on a rising clock edge
// where tx_busy is low. tx_data is sampled only on that accepting edge.
// tx_busy stays high for the whole frame. tx_done pulses for one cycle when
// the stop bit ends. A request made while tx_busy is high is dropped, not
// queued.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       tx_done;

   modport master (output tx_data, output tx_start, input tx_busy, input tx_done);
   modport slave  (input tx_data, input tx_start, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter. It sends a start bit, 8 data bits LSB first, an optional
// parity bit and a stop bit. Each bit lasts CLKS_PER_BIT system clocks. The
// serial line, busy and done outputs all come straight from registers.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 434,
   parameter bit PARITY_EN    = 1'b1,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   uart_tx_if.slave   bus,
   output logic       tx,
   output logic [2:0] state_dbg
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          parity_bit;
   logic          busy_r;
   logic          done_r;
   logic          bit_end;

   // Last clock of the current serial bit.
   assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign bus.tx_busy = busy_r;
   assign bus.tx_done = done_r;
   assign state_dbg = state;

   // Frame sequencer. tx is loaded with the next bit value on the same edge
   // that changes the bit, so the pin never shows an intermediate value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tx         <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               tx     <= 1'b1;
               busy_r <= 1'b0;
               if (bus.tx_start) begin
                  shift      <= bus.tx_data;
                  parity_bit <= PARITY_ODD ? ~(^bus.tx_data) : (^bus.tx_data);
                  baud_cnt   <= '0;
                  bit_idx    <= '0;
                  tx         <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     if (PARITY_EN) begin
                        tx    <= parity_bit;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     tx <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx     <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame. It uses three instances: even parity,
// odd parity, and no parity. All use 434 clocks per bit.
module tb_uart_tx_frame;

   localparam int B = 434;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] data = 8'h00;
   int         sel = 0;
   int         checks = 0;
   int         errors = 0;

   uart_tx_if if0 ();
   uart_tx_if if1 ();
   uart_tx_if if2 ();
   logic       tx0, tx1, tx2;
   logic [2:0] st0, st1, st2;
   logic       tx_o, busy_o, done_o;

   assign if0.tx_data  = data;
   assign if1.tx_data  = data;
   assign if2.tx_data  = data;
   assign if0.tx_start = start && (sel == 0);
   assign if1.tx_start = start && (sel == 1);
   assign if2.tx_start = start && (sel == 2);

   assign tx_o   = (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
   assign busy_o = (sel == 0) ? if0.tx_busy : (sel == 1) ? if1.tx_busy : if2.tx_busy;
   assign done_o = (sel == 0) ? if0.tx_done : (sel == 1) ? if1.tx_done : if2.tx_done;

   uart_tx_frame #(.CLKS_PER_BIT(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst(rst), .bus(if0.slave), .tx(tx0), .state_dbg(st0));
   uart_tx_frame #(.CLKS_PER_BIT(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst(rst), .bus(if1.slave), .tx(tx1), .state_dbg(st1));
   uart_tx_frame #(.CLKS_PER_BIT(B), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_nopar (
      .clk(clk), .rst(rst), .bus(if2.slave), .tx(tx2), .state_dbg(st2));

   // Clock and reset block
   always #5 clk = ~clk;

   // Driver and checker for one frame. It is called at a negedge; the next
   // posedge is the accepting edge N. Each bit must be constant for all B
   // cycles, with busy high and done low. The task returns at the negedge
   // of cycle N+nbits*B+1, after checking the done pulse there. If
   // pulse_at > 0, a second request with data 0xFF is pulsed at that cycle
   // offset. Data is randomised after acceptance.
   task automatic run_frame(input logic [7:0] d, input logic [10:0] bits,
                            input int nbits, input int pulse_at, input string tag);
      int  j;
      bit  bad;
      logic o_tx, o_busy, o_done;
      data  = d;
      start = 1'b1;
      @(negedge clk);
      j = 1;
      for (int k = 0; k < nbits; k++) begin
         bad = 1'b0;
         o_tx = bits[k];
         o_busy = 1'b1;
         o_done = 1'b0;
         for (int c = 0; c < B; c++) begin
            if (!bad && (tx_o !== bits[k] || busy_o !== 1'b1 || done_o !== 1'b0)) begin
               bad = 1'b1;
               o_tx = tx_o;
               o_busy = busy_o;
               o_done = done_o;
            end
            if (pulse_at > 0 && j == pulse_at) begin
               data  = 8'hFF;
               start = 1'b1;
            end else begin
               start = 1'b0;
               data  = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            j++;
         end
         checks++;
         assert (bad === 1'b0) else begin
            errors++;
            $error("FAIL %s bit%0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                   tag, k, o_tx, o_busy, o_done, bits[k]);
         end
      end
      checks++;
      assert ({done_o, busy_o, tx_o} === 3'b101) else begin
         errors++;
         $error("FAIL %s done_cycle: done=%b busy=%b tx=%b, expected done=1 busy=0 tx=1",
                tag, done_o, busy_o, tx_o);
      end
   endtask

   // After a done cycle with no new request, check that done drops, and
   // that the line stays idle for two bit times (no queued frame).
   task automatic check_idle_after(input string tag);
      bit bad;
      start = 1'b0;
      @(negedge clk);
      checks++;
      assert (done_o === 1'b0) else begin
         errors++;
         $error("FAIL %s done_width: done=%b, expected 0", tag, done_o);
      end
      bad = 1'b0;
      for (int c = 0; c < 2 * B; c++) begin
         if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      assert (bad === 1'b0) else begin
         errors++;
         $error("FAIL %s idle_after: line not idle, got bad=%b expected 0", tag, bad);
      end
   endtask

   initial begin
      bit bad;
      sel = 0;
      // Reset for two cycles, then stay idle for 1000 cycles.
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         if (tx0 !== 1'b1 || if0.tx_busy !== 1'b0 || if0.tx_done !== 1'b0 ||
             tx1 !== 1'b1 || if1.tx_busy !== 1'b0 ||
             tx2 !== 1'b1 || if2.tx_busy !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      assert (bad === 1'b0) else begin
         errors++;
         $error("FAIL reset_idle: outputs left idle, got bad=%b expected 0", bad);
      end

      // Reset and start in the same cycle: reset wins.
      rst = 1'b1;
      start = 1'b1;
      data = 8'h0C;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checks++;
      assert ({busy_o, tx_o} === 2'b01) else begin
         errors++;
         $error("FAIL rst_vs_start: busy=%b tx=%b, expected busy=0 tx=1", busy_o, tx_o);
      end

      // Frame 0x0C with even parity (parity bit 0).
      run_frame(8'h0C, {1'b1, 1'b0, 8'h0C, 1'b0}, 11, 0, "even_0C");
      check_idle_after("even_0C");

      // Back-to-back: 0x08 (parity 1), start held in the done cycle, then
      // 0x55 (parity 0).
      run_frame(8'h08, {1'b1, 1'b1, 8'h08, 1'b0}, 11, 0, "b2b_08");
      run_frame(8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 11, 0, "b2b_55");
      check_idle_after("b2b_55");

      // A request with data 0xFF during data bit 2 of 0x0C is ignored.
      run_frame(8'h0C, {1'b1, 1'b0, 8'h0C, 1'b0}, 11, 1 + 3 * B + 50, "busy_ign");
      check_idle_after("busy_ign");

      // Reset during data bit 3: the line is idle next cycle, with no done.
      data = 8'h0C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 1 + 4 * B + 100; c++) @(negedge clk);
      checks++;
      assert (tx_o === 1'b1 && busy_o === 1'b1) else begin
         errors++;
         $error("FAIL pre_abort: tx=%b busy=%b, expected tx=1 (bit3 of 0C) busy=1", tx_o, busy_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      assert ({done_o, busy_o, tx_o} === 3'b001) else begin
         errors++;
         $error("FAIL abort: done=%b busy=%b tx=%b, expected done=0 busy=0 tx=1",
                done_o, busy_o, tx_o);
      end
      bad = 1'b0;
      for (int c = 0; c < 8 * B; c++) begin
         if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      assert (bad === 1'b0) else begin
         errors++;
         $error("FAIL abort_quiet: activity after abort, got bad=%b expected 0", bad);
      end
      run_frame(8'h0C, {1'b1, 1'b0, 8'h0C, 1'b0}, 11, 0, "after_abort");
      check_idle_after("after_abort");

      // Odd parity: 0x55 has four ones, so the parity bit is 1.
      sel = 1;
      @(negedge clk);
      run_frame(8'h55, {1'b1, 1'b1, 8'h55, 1'b0}, 11, 0, "odd_55");
      check_idle_after("odd_55");

      // No parity: a 10-bit frame, with done at N+4341.
      sel = 2;
      @(negedge clk);
      run_frame(8'hAA, {1'b0, 1'b1, 8'hAA, 1'b0}, 10, 0, "nopar_AA");
      check_idle_after("nopar_AA");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
